// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the data-memory port arbiter.
// FSM states, owner encoding and the fetch byte mask.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } arb_owner_e;

  localparam logic [3:0] FETCH_MASK = 4'b1111;

endpackage

// File: rtl/arb_timeout_counter.sv
// arb_timeout_counter: counts WAIT cycles for one transaction.
// expired flags the last allowed cycle so the owner can be aborted.
module arb_timeout_counter #(
  parameter int TimeoutCycles = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TimeoutCycles);
  localparam logic [W-1:0] LAST = W'(TimeoutCycles - 1);

  logic [W-1:0] cnt_q;

  // count enabled cycles, stop at the last one, wipe on clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the data-memory port between fetch
// and load/store, with bounded fetch starvation and a timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int MaxLsBurst    = 4,
  parameter int TimeoutCycles = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [DataWidth-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_valid,
  output logic [DataWidth-1:0] if_rdata,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [3:0]           ls_mask,
  input  logic [DataWidth-1:0] ls_addr,
  input  logic [DataWidth-1:0] ls_wdata,
  output logic                 ls_gnt,
  output logic                 ls_valid,
  output logic [DataWidth-1:0] ls_rdata,
  output logic                 rsp_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [3:0]           mem_mask,
  output logic [DataWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic                 mem_valid,
  input  logic [DataWidth-1:0] mem_rdata
);

  localparam int SW = 4;
  localparam logic [SW-1:0] MAX_BURST = SW'(MaxLsBurst);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;

  logic [SW-1:0] starve_q;
  logic          starved;
  logic          pick_ls;
  logic          pick_if;
  logic          in_wait;
  logic          expired;
  logic          abort;
  logic          rsp_fire;

  assign starved = (starve_q == MAX_BURST);
  assign pick_ls = ls_req && !(if_req && starved);
  assign pick_if = if_req && !pick_ls;
  assign in_wait = (state_q == WAIT);
  assign abort   = expired && !mem_valid;
  assign rsp_fire = in_wait && (mem_valid || expired);

  arb_timeout_counter #(
    .TimeoutCycles(TimeoutCycles)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(expired)
  );

  // state and owner registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_LS;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // next state, grants and response steering
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    if_gnt   = 1'b0;
    ls_gnt   = 1'b0;
    mem_req  = 1'b0;
    if_valid = 1'b0;
    ls_valid = 1'b0;
    if_rdata = '0;
    ls_rdata = '0;
    rsp_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rst) begin
          unique case (1'b1)
            pick_ls: begin
              ls_gnt  = 1'b1;
              owner_d = OWN_LS;
              state_d = ISSUE;
            end
            pick_if: begin
              if_gnt  = 1'b1;
              owner_d = OWN_IF;
              state_d = ISSUE;
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        mem_req = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        rsp_err = abort;
        if (owner_q == OWN_IF) begin
          if_valid = rsp_fire;
          if_rdata = abort ? '0 : mem_rdata;
        end else begin
          ls_valid = rsp_fire;
          ls_rdata = abort ? '0 : mem_rdata;
        end
        if (rsp_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // LS-in-a-row counter while fetch waits
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (!if_req || if_gnt) begin
      starve_q <= '0;
    end else if (ls_gnt && !starved) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  // capture granted payload; held until the next grant
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_mask  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (ls_gnt) begin
      mem_we    <= ls_we;
      mem_mask  <= ls_mask;
      mem_addr  <= ls_addr;
      mem_wdata <= ls_wdata;
    end else if (if_gnt) begin
      mem_we    <= 1'b0;
      mem_mask  <= FETCH_MASK;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a response scoreboard.
// Burst limit 4, timeout 8 cycles.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_mask;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_valid;
  logic [31:0] ls_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        ls;
    logic        err;
    logic        dc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DataWidth    (32),
    .MaxLsBurst   (4),
    .TimeoutCycles(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_mask  (ls_mask),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_gnt   (ls_gnt),
    .ls_valid (ls_valid),
    .ls_rdata (ls_rdata),
    .rsp_err  (rsp_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_mask (mem_mask),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_valid(mem_valid),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic push(input logic ls, input logic err,
                      input logic dc, input logic [31:0] d);
    exp_t e;
    e.ls   = ls;
    e.err  = err;
    e.dc   = dc;
    e.data = d;
    sb.push_back(e);
  endtask

  // response monitor: pops the scoreboard on every valid pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      chk("one_gnt", {31'b0, if_gnt & ls_gnt}, 32'd0);
      chk("one_valid", {31'b0, if_valid & ls_valid}, 32'd0);
      if (if_valid || ls_valid) begin
        if (sb.size() == 0) begin
          chk("unexp_rsp", {30'b0, if_valid, ls_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_owner", {31'b0, ls_valid}, {31'b0, e.ls});
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          if (!e.dc) begin
            chk("rsp_data", e.ls ? ls_rdata : if_rdata, e.data);
          end
        end
      end
    end
  end

  logic exp_order [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst       = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    ls_req    = 1'b0;
    ls_we     = 1'b0;
    ls_mask   = '0;
    ls_addr   = '0;
    ls_wdata  = '0;
    mem_valid = 1'b0;
    mem_rdata = '0;

    // reset state
    cyc();
    cyc();
    at_neg();
    chk("rst_gnt", {30'b0, if_gnt, ls_gnt}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_mask", {28'b0, mem_mask}, 32'd0);
    chk("rst_valid", {29'b0, if_valid, ls_valid, rsp_err}, 32'd0);
    cyc();
    rst = 1'b1;

    // single fetch
    cyc();
    if_req  = 1'b1;
    if_addr = 32'h100;
    at_neg();
    chk("f_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("f_ls_gnt", {31'b0, ls_gnt}, 32'd0);
    push(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    cyc();
    if_req = 1'b0;
    at_neg();
    chk("f_mem_req", {31'b0, mem_req}, 32'd1);
    chk("f_mask", {28'b0, mem_mask}, 32'hF);
    chk("f_we", {31'b0, mem_we}, 32'd0);
    chk("f_addr", mem_addr, 32'h100);
    cyc();
    at_neg();
    chk("f_req_once", {31'b0, mem_req}, 32'd0);
    cyc();
    mem_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    at_neg();
    chk("f_valid", {31'b0, if_valid}, 32'd1);
    chk("f_rdata", if_rdata, 32'hDEAD_BEEF);
    cyc();
    mem_valid = 1'b0;

    // store
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_mask  = 4'b0011;
    ls_addr  = 32'h204;
    ls_wdata = 32'h1234;
    at_neg();
    chk("s_ls_gnt", {31'b0, ls_gnt}, 32'd1);
    push(1'b1, 1'b0, 1'b1, 32'd0);
    cyc();
    ls_req = 1'b0;
    at_neg();
    chk("s_mem_req", {31'b0, mem_req}, 32'd1);
    chk("s_we", {31'b0, mem_we}, 32'd1);
    chk("s_mask", {28'b0, mem_mask}, 32'h3);
    chk("s_addr", mem_addr, 32'h204);
    cyc();
    cyc();
    at_neg();
    chk("s_hold_we", {31'b0, mem_we}, 32'd1);
    chk("s_hold_mask", {28'b0, mem_mask}, 32'h3);
    chk("s_hold_wdata", mem_wdata, 32'h1234);
    chk("s_no_valid", {31'b0, ls_valid}, 32'd0);
    cyc();
    mem_valid = 1'b1;
    mem_rdata = 32'hAAAA_AAAA;
    at_neg();
    chk("s_valid", {31'b0, ls_valid}, 32'd1);
    cyc();
    mem_valid = 1'b0;

    // contention: LS x4, then IF, then LS
    if_req  = 1'b1;
    if_addr = 32'h400;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_mask = 4'hF;
    ls_addr = 32'h300;
    for (int i = 0; i < 6; i++) begin
      at_neg();
      chk($sformatf("order%0d", i), {30'b0, ls_gnt, if_gnt},
          exp_order[i] ? 32'd2 : 32'd1);
      push(exp_order[i], 1'b0, 1'b0, 32'hC000_0000 + 32'(i));
      cyc();
      cyc();
      mem_valid = 1'b1;
      mem_rdata = 32'hC000_0000 + 32'(i);
      cyc();
      mem_valid = 1'b0;
    end
    if_req = 1'b0;
    ls_req = 1'b0;

    // timeout on a silent load
    cyc();
    ls_req  = 1'b1;
    ls_addr = 32'h500;
    at_neg();
    chk("t_gnt", {31'b0, ls_gnt}, 32'd1);
    push(1'b1, 1'b1, 1'b0, 32'd0);
    cyc();
    ls_req    = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    cyc();
    for (int k = 0; k < 7; k++) begin
      at_neg();
      chk($sformatf("t_wait%0d", k), {31'b0, ls_valid}, 32'd0);
      cyc();
    end
    at_neg();
    chk("t_valid", {31'b0, ls_valid}, 32'd1);
    chk("t_err", {31'b0, rsp_err}, 32'd1);
    chk("t_rdata", ls_rdata, 32'd0);
    cyc();
    cyc();
    cyc();
    mem_valid = 1'b1;
    at_neg();
    chk("t_late", {30'b0, if_valid, ls_valid}, 32'd0);
    cyc();
    mem_valid = 1'b0;

    // response in the same cycle as the timeout
    ls_req  = 1'b1;
    ls_addr = 32'h508;
    at_neg();
    chk("x_gnt", {31'b0, ls_gnt}, 32'd1);
    push(1'b1, 1'b0, 1'b0, 32'h5A5A_5A5A);
    cyc();
    ls_req = 1'b0;
    cyc();
    for (int k = 0; k < 7; k++) begin
      cyc();
    end
    mem_valid = 1'b1;
    mem_rdata = 32'h5A5A_5A5A;
    at_neg();
    chk("x_valid", {31'b0, ls_valid}, 32'd1);
    chk("x_err", {31'b0, rsp_err}, 32'd0);
    chk("x_rdata", ls_rdata, 32'h5A5A_5A5A);
    cyc();
    mem_valid = 1'b0;

    // reset in the middle of WAIT
    if_req  = 1'b1;
    if_addr = 32'h700;
    at_neg();
    chk("r_gnt0", {31'b0, if_gnt}, 32'd1);
    cyc();
    if_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    at_neg();
    chk("r_gnt_low", {30'b0, if_gnt, ls_gnt}, 32'd0);
    cyc();
    rst       = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 32'h77;
    if_req    = 1'b1;
    if_addr   = 32'h600;
    at_neg();
    chk("r_req", {31'b0, mem_req}, 32'd0);
    chk("r_addr", mem_addr, 32'd0);
    chk("r_mask", {28'b0, mem_mask}, 32'd0);
    chk("r_valid", {29'b0, if_valid, ls_valid, rsp_err}, 32'd0);
    chk("r_new_gnt", {31'b0, if_gnt}, 32'd1);
    push(1'b0, 1'b0, 1'b0, 32'h600D);
    cyc();
    if_req    = 1'b0;
    mem_valid = 1'b0;
    at_neg();
    chk("r_new_addr", mem_addr, 32'h600);
    cyc();
    mem_valid = 1'b1;
    mem_rdata = 32'h600D;
    at_neg();
    chk("r_new_valid", {31'b0, if_valid}, 32'd1);
    cyc();
    mem_valid = 1'b0;
    cyc();
    cyc();
    at_neg();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single core data-memory port between the fetch unit and the memory stage load/store path. The block accepts one request at a time from either requester, gives load/store priority with a bounded-starvation guarantee for fetch, and sequences the memory request/response handshake. Each transaction has a timeout, so a silent memory cannot hang the pipeline. It sits between the pipeline front-end/memory stage and the memory wrapper.

## Interface
- DataWidth, 32, data and address width
- MaxLsBurst, 4, consecutive LS grants allowed while IF is waiting; range 1–15
- TimeoutCycles, 64, WAIT cycles before a transaction is aborted; range 2–255
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  DataWidth  fetch address
- if_gnt  out  1  one-cycle pulse; fetch payload captured
- if_valid  out  1  one-cycle pulse; fetch response
- if_rdata  out  DataWidth  fetch data; valid with if_valid
- ls_req  in  1  load/store request; held until ls_gnt
- ls_we  in  1  1 = store
- ls_mask  in  4  byte mask
- ls_addr  in  DataWidth  load/store address
- ls_wdata  in  DataWidth  store data
- ls_gnt  out  1  one-cycle pulse; LS payload captured
- ls_valid  out  1  one-cycle pulse; LS response
- ls_rdata  out  DataWidth  load data; valid with ls_valid
- rsp_err  out  1  qualifies if_valid/ls_valid; 1 = timeout abort
- mem_req  out  1  memory request; one-cycle pulse
- mem_we  out  1  memory write enable
- mem_mask  out  4  memory byte mask; 4'b1111 for fetch
- mem_addr  out  DataWidth  memory address
- mem_wdata  out  DataWidth  memory write data
- mem_valid  in  1  memory response strobe
- mem_rdata  in  DataWidth  memory read data

## Operation
- States: IDLE, ISSUE, WAIT. A 1-bit owner register records IF or LS.
- IDLE: arbitration is combinational on the current req inputs.
  - ls_req alone: grant LS.
  - if_req alone: grant IF.
  - Both: grant LS, unless the starvation counter equals MaxLsBurst; then grant IF.
- Starvation counter:
  - Increments on an LS grant while if_req=1.
  - Clears on any IF grant, and in any cycle where if_req=0.
  - Saturates at MaxLsBurst.
- On a grant: the gnt pulse is raised in the same cycle, the payload is latched into the mem_* registers, the owner is set, and the state moves to ISSUE.
  - For fetch: mem_we=0, mem_mask=4'b1111, mem_wdata=0.
- ISSUE: mem_req=1 for exactly one cycle, then WAIT. mem_valid seen in ISSUE is ignored; memory must respond no earlier than one cycle after mem_req.
- WAIT: the owner's valid equals mem_valid (combinational); the owner's rdata passes mem_rdata through; rsp_err=0. On mem_valid, go to IDLE.
- Timeout: a cycle counter runs in WAIT and clears on entry. If it reaches TimeoutCycles-1 without mem_valid:
  - Pulse the owner's valid with rsp_err=1 and rdata=0.
  - Go to IDLE.
- mem_valid received in IDLE (late response after an abort) is dropped. No requester valid is raised.
- Store responses also pulse ls_valid; ls_rdata is don't-care for stores.
- mem_addr, mem_we, mem_mask and mem_wdata hold stable from ISSUE until the state leaves WAIT.

## Timing
- Reset (rst=0 at clk edge):
  - State → IDLE; owner → LS.
  - Both counters → 0.
  - All outputs → 0, including the mem_* payload registers.
  - gnt outputs are low while rst=0.
- Reset mid-transaction abandons the transaction. No response is delivered; late mem_valid is dropped.
- Latency: gnt at cycle 0, mem_req at cycle 1, earliest response at cycle 2, next grant at cycle 3 at the earliest. Best-case throughput is one transaction per 3 cycles.
- Requesters must hold req and payload stable until gnt. The req inputs are ignored outside IDLE.
- If mem_valid and the timeout occur in the same cycle, mem_valid wins: rsp_err=0 and the real data is delivered.
- The valid outputs are never both high. The gnt outputs are never both high.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum arb_state_e {IDLE, ISSUE, WAIT}
  - typedef enum arb_owner_e {OWN_IF, OWN_LS}
  - constant FETCH_MASK = 4'b1111
- One sub-module: arb_timeout_counter.
  - Inputs: clear, enable.
  - Output: expired.
  - Width: $clog2(TimeoutCycles).
- Arbitration and the FSM stay in the top module.

## Test plan
- Single fetch: if_req=1, if_addr=0x100; memory answers 2 cycles after mem_req with 0xDEADBEEF. Expect if_gnt at cycle 0, mem_req at cycle 1 with mask 1111 and we=0, if_valid with 0xDEADBEEF, rsp_err=0.
- Store: ls_req, ls_we=1, mask=0011, addr=0x204, wdata=0x1234. Expect mem_we=1, mem_mask=0011, mem_wdata=0x1234 held through WAIT, ls_valid on mem_valid.
- Contention with MaxLsBurst=4: if_req and ls_req both held continuously. Expect grant order LS,LS,LS,LS,IF,LS,…
- Timeout with TimeoutCycles=8: memory never responds to a load. Expect ls_valid with rsp_err=1 and ls_rdata=0 after 8 WAIT cycles. A late mem_valid 3 cycles later produces no valid.
- Simultaneous events: mem_valid arrives in the same cycle as the timeout. Expect rsp_err=0 and the data delivered.
- Reset mid-WAIT: assert rst=0 for one cycle. Expect all outputs 0 and state IDLE; a subsequent mem_valid is ignored; a new if_req is granted immediately after reset.
